operand_serializer: RTL and testbench
=====================================

# operand_serializer

Parallel-in, serial-out operand feeder for the single-full-adder serial adder. It captures two WIDTH-bit operands and a carry-in in one handshake, then presents them LSB-first, one bit pair per accepted cycle, to the full adder. The adder's sum bits go into the existing serial-in result shift register. It is the transmit end of the bit-serial datapath; the result shifter is the receive end.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  producer offers a_in, b_in and cin_in.
- load_ready  out  1  serializer can accept operands this cycle.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- cin_in  in  1  initial carry for the addition.
- bit_valid  out  1  a_bit, b_bit and carry_bit are meaningful.
- bit_ready  in  1  adder/result side consumes the current bit pair. This is the same signal as the result shifter's enable.
- a_bit  out  1  current bit of A; LSB first.
- b_bit  out  1  current bit of B; LSB first.
- carry_bit  out  1  equals captured cin_in while bit_first is high, otherwise 0.
- bit_first  out  1  current pair is bit 0.
- bit_last  out  1  current pair is bit WIDTH-1.
- busy  out  1  high whenever state is SHIFT.

## Operation
- FSM has two states:
  - IDLE: load_ready = 1, bit_valid = 0.
  - SHIFT: bit_valid = 1.
- Load: when load_valid && load_ready, capture a_in, b_in and cin_in, clear the bit counter, and go to SHIFT.
- Shift: in SHIFT, each cycle with bit_ready = 1 shifts both operand registers right by one (a 0 enters the MSB) and increments the counter.
  - With bit_ready = 0, all outputs hold. This stall has no time limit.
- Outputs a_bit and b_bit are always the LSBs of the operand registers.
- bit_first = (count == 0) && SHIFT; bit_last = (count == WIDTH-1) && SHIFT.
- Counter is $clog2(WIDTH) bits wide and never exceeds WIDTH-1; it does not wrap within one operand.
- When bit_last && bit_ready, the transfer completes; the next state depends on the macro (see Configuration).
- load_valid is ignored while load_ready = 0; operands are never overwritten mid-transfer.
- Reset (asserted at any time, including mid-transfer):
  - State goes to IDLE; operand registers, counter and captured carry clear to 0.
  - Outputs: load_ready = 1, bit_valid = 0, a_bit = b_bit = carry_bit = 0, bit_first = bit_last = 0, busy = 0.
  - The partial transfer is discarded.

## Timing
- Load accepted in cycle N: bit 0 is presented in cycle N+1, with bit_valid = 1 and bit_first = 1.
- With bit_ready held high: bit k is presented in cycle N+1+k, and bit_last appears in cycle N+WIDTH.
- Minimum transfer is WIDTH cycles of bit_valid per operand pair.
- Back-to-back loads without the macro: the next load_ready rises in cycle N+WIDTH+1. Throughput is WIDTH+1 cycles per operand pair.
- bit_valid, data and flags change only after a clock edge on which bit_ready was 1, or on load.
- load_ready and busy are combinational from state (plus bit_last/bit_ready with the macro); there is no other combinational input-to-output path.
- Reset deassertion is synchronised externally; the first load can be accepted on the first edge after release.

## Configuration
- SERIALIZER_AUTO_RELOAD_EN defined:
  - load_ready = IDLE || (bit_last && bit_ready).
  - A load in the last-bit cycle captures the new operands, and bit 0 of the new pair is presented in the next cycle with no bubble.
  - Throughput is WIDTH cycles per pair.
  - If no load occurs on that edge, the FSM goes to IDLE.
- SERIALIZER_AUTO_RELOAD_EN undefined:
  - load_ready = IDLE only.
  - The FSM always returns to IDLE for at least one cycle after the last bit.

## Structure
- Package operand_serializer_pkg holds:
  - the state enum (SER_IDLE, SER_SHIFT);
  - the default width constant SER_WIDTH = 8;
  - a function returning the counter width, $clog2(WIDTH).
- One sub-module, piso_shift_reg: a WIDTH-bit parallel-load, shift-right register with load, shift-enable and active-low asynchronous reset. It is instantiated twice, once for A and once for B.
- FSM, counter, carry capture and handshake logic live in operand_serializer.

## Test plan
- Reset mid-transfer: load A=0xA5, B=0x3C, let 3 bits pass, assert rst -> next cycle bit_valid=0, load_ready=1, all bit outputs 0; a fresh load then starts at bit_first.
- Basic serialization (WIDTH=8, bit_ready=1): load A=0xA5, B=0x3C, cin=1 -> a_bit sequence 1,0,1,0,0,1,0,1; b_bit sequence 0,0,1,1,1,1,0,0; carry_bit=1 only on bit 0; bit_last in cycle N+8.
- Stall: same load, bit_ready low for 5 cycles at bit 3 -> a_bit, b_bit, bit_valid and the counter hold; the sequence resumes at bit 3 with no loss or duplication.
- Load during busy: load_valid pulsed with A=0xFF mid-transfer -> ignored; the current sequence completes unchanged.
- Back-to-back: two pairs offered continuously -> without the macro, 9 cycles between bit_first pulses; with SERIALIZER_AUTO_RELOAD_EN, 8 cycles and no bit_valid gap.
- End-to-end: feed bits through a full adder into the result shifter, sweeping 0+0, 0xFF+0x01, 0x7F+0x80 with cin=1 -> captured sums 0x000, 0x100, 0x100.

Source files
------------

// File: rtl/operand_serializer_pkg.sv
// Shared types and constants for the bit-serial operand feeder.
package operand_serializer_pkg;

    typedef enum logic {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

    localparam int unsigned SER_WIDTH = 8;

    function automatic int unsigned ser_cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-right register; the serial output is the current LSB.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             ser_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load wins over shift so a new operand can replace the last bit in one edge.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_out = data_q[0];

endmodule

// File: rtl/operand_serializer.sv
// Parallel-in, serial-out operand feeder for the serial full adder, LSB first.
// Define SERIALIZER_AUTO_RELOAD_EN to accept the next pair on the last-bit cycle.
module operand_serializer
    import operand_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             a_bit,
    output logic             b_bit,
    output logic             carry_bit,
    output logic             bit_first,
    output logic             bit_last,
    output logic             busy
);

    localparam int unsigned CW = ser_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ser_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          cin_q, cin_d;
    logic          shifting;
    logic          load_fire;
    logic          shift_fire;
    logic          done;

    assign shifting   = (state_q == SER_SHIFT);
    assign bit_first  = shifting && (count_q == '0);
    assign bit_last   = shifting && (count_q == LAST_IDX);
    assign done       = bit_last && bit_ready;
    assign shift_fire = shifting && bit_ready;

`ifdef SERIALIZER_AUTO_RELOAD_EN
    assign load_ready = (state_q == SER_IDLE) || done;
`else
    assign load_ready = (state_q == SER_IDLE);
`endif

    assign load_fire = load_valid && load_ready;
    assign bit_valid = shifting;
    assign busy      = shifting;
    assign carry_bit = bit_first && cin_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_IDLE: begin
                if (load_fire) begin
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (done) begin
                    state_d = load_fire ? SER_SHIFT : SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // Counter parks at the last index after completion; bit_last is gated by state.
    always_comb begin
        count_d = count_q;
        cin_d   = cin_q;
        if (load_fire) begin
            count_d = '0;
            cin_d   = cin_in;
        end else if (shift_fire && !bit_last) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SER_IDLE;
            count_q <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cin_q   <= cin_d;
        end
    end

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_a (
        .clk     (clk),
        .rst     (rst),
        .load    (load_fire),
        .shift   (shift_fire),
        .din     (a_in),
        .ser_out (a_bit)
    );

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_b (
        .clk     (clk),
        .rst     (rst),
        .load    (load_fire),
        .shift   (shift_fire),
        .din     (b_in),
        .ser_out (b_bit)
    );

endmodule

// File: tb/tb_operand_serializer.sv
// Directed bench for operand_serializer with a bit-pair scoreboard and adder model.
module tb_operand_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         bit_valid;
    logic         bit_ready;
    logic         a_bit;
    logic         b_bit;
    logic         carry_bit;
    logic         bit_first;
    logic         bit_last;
    logic         busy;

    operand_serializer #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .cin_in     (cin_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .carry_bit  (carry_bit),
        .bit_first  (bit_first),
        .bit_last   (bit_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int load_cyc;
    int last_cyc;
    int first_cycs[$];
    logic [4:0] exp_q[$];   // {a, b, carry, first, last}
    logic loaded;
    logic fa_c;
    logic [W-1:0] res_sr;
    logic [W:0]   sum_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full adder plus serial-in result shifter fed from the DUT outputs.
    task automatic adder_step();
        logic ci, s;
        ci     = bit_first ? carry_bit : fa_c;
        s      = a_bit ^ b_bit ^ ci;
        fa_c   = (a_bit & b_bit) | (a_bit & ci) | (b_bit & ci);
        res_sr = {s, res_sr[W-1:1]};
        if (bit_last) sum_out = {fa_c, res_sr};
    endtask

    task automatic tick();
        logic [4:0] obs;
        #1;
        if (bit_valid) begin
            if (bit_first) first_cycs.push_back(cyc);
            if (bit_last) last_cyc = cyc;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                obs = {a_bit, b_bit, carry_bit, bit_first, bit_last};
                if (bit_ready) begin
                    chk("bit_pair", 32'(obs), 32'(exp_q.pop_front()));
                    adder_step();
                end else begin
                    chk("stall_hold", 32'(obs), 32'(exp_q[0]));
                end
            end
        end
        if (load_valid && load_ready) begin
            loaded   = 1'b1;
            load_cyc = cyc;
            for (int k = 0; k < W; k++) begin
                exp_q.push_back({a_in[k], b_in[k], (k == 0) ? cin_in : 1'b0,
                                 k == 0, k == W - 1});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_in       = a;
        b_in       = b;
        cin_in     = c;
        load_valid = 1'b1;
        loaded     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (loaded) break;
        end
        load_valid = 1'b0;
        chk("load_accept", 32'(loaded), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !bit_valid) break;
            tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("drain_idle", {31'd0, bit_valid}, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {24'd0, load_ready, bit_valid, a_bit, b_bit, carry_bit,
                  bit_first, bit_last, busy}, 32'b1000_0000);
    endtask

    logic [W:0] e2e_exp[3];
    logic [W-1:0] e2e_a[3];
    logic [W-1:0] e2e_b[3];
    logic         e2e_c[3];

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        bit_ready  = 1'b1;
        a_in       = '0;
        b_in       = '0;
        cin_in     = 1'b0;
        fa_c       = 1'b0;
        res_sr     = '0;
        sum_out    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst = 1'b1;

        // Reset mid-transfer
        do_load(8'hA5, 8'h3C, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset_async");
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_reset_outputs("reset_held");
        rst = 1'b1;

        // Basic serialization, fresh load starts at bit_first
        first_cycs.delete();
        do_load(8'hA5, 8'h3C, 1'b1);
        drain();
        chk("first_latency", 32'(first_cycs[0] - load_cyc), 1);
        chk("last_latency", 32'(last_cyc - load_cyc), W);

        // Stall five cycles at bit 3
        do_load(8'hA5, 8'h3C, 1'b1);
        repeat (3) tick();
        bit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, bit_valid}, 1);
        end
        bit_ready = 1'b1;
        drain();

        // Load offered while busy is ignored
        do_load(8'h5A, 8'hC3, 1'b0);
        repeat (2) tick();
        a_in       = 8'hFF;
        b_in       = 8'hFF;
        cin_in     = 1'b1;
        load_valid = 1'b1;
        #1;
        chk("busy_not_ready", {31'd0, load_ready}, 0);
        repeat (2) tick();
        load_valid = 1'b0;
        drain();

        // Back-to-back loads
        first_cycs.delete();
        do_load(8'h12, 8'h34, 1'b0);
        do_load(8'h56, 8'h78, 1'b1);
        drain();
        chk("b2b_firsts", 32'(first_cycs.size()), 2);
`ifdef SERIALIZER_AUTO_RELOAD_EN
        chk("b2b_spacing", 32'(first_cycs[1] - first_cycs[0]), W);
`else
        chk("b2b_spacing", 32'(first_cycs[1] - first_cycs[0]), W + 1);
`endif

        // End-to-end through the adder model
        e2e_a[0] = 8'h00; e2e_b[0] = 8'h00; e2e_c[0] = 1'b0; e2e_exp[0] = 9'h000;
        e2e_a[1] = 8'hFF; e2e_b[1] = 8'h01; e2e_c[1] = 1'b0; e2e_exp[1] = 9'h100;
        e2e_a[2] = 8'h7F; e2e_b[2] = 8'h80; e2e_c[2] = 1'b1; e2e_exp[2] = 9'h100;
        for (int v = 0; v < 3; v++) begin
            sum_out = 9'h1FF;
            do_load(e2e_a[v], e2e_b[v], e2e_c[v]);
            drain();
            chk($sformatf("e2e_sum%0d", v), 32'(sum_out), 32'(e2e_exp[v]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
